// File: rtl/robertson_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : robertson_mul_seq_if
//  Description : Handshake / result bundle for the sequential Robertson
//                signed multiplier.
//                master : requester side (drives start and operands)
//                slave  : multiplier side (drives status and results)
//  Ports       : start, m_i, q_i           -> operand request
//                busy, done                -> status
//                res_o, res_valid, res_hi  -> two-beat serial result
//                product                   -> full 2*WIDTH-bit product
//  Revision    : 1.0  initial release
// ============================================================================
interface robertson_mul_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     m_i;
  logic [WIDTH-1:0]     q_i;
  logic                 busy;
  logic [WIDTH-1:0]     res_o;
  logic                 res_valid;
  logic                 res_hi;
  logic [2*WIDTH-1:0]   product;
  logic                 done;

  modport master (
    output start, m_i, q_i,
    input  busy, res_o, res_valid, res_hi, product, done
  );

  modport slave (
    input  start, m_i, q_i,
    output busy, res_o, res_valid, res_hi, product, done
  );
endinterface
`default_nettype wire

// File: rtl/robertson_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : robertson_mul_seq
//  Description : Sequential two's-complement multiplier (Robertson's method).
//                WIDTH-1 add/shift iterations over the multiplier bits, then
//                a sign-correction subtract for the multiplier MSB and a
//                final shift. The 2*WIDTH-bit result is presented in parallel
//                on product and serially as two beats (high half first).
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous, active-high reset
//                bus      - robertson_mul_seq_if.slave
//                           (start, m_i, q_i in; busy, res_o, res_valid,
//                            res_hi, product, done out)
//  Parameters  : WIDTH    - operand width, 4..32
//  Macro       : ROBERTSON_ZERO_SKIP_EN - when defined, a zero operand seen in
//                LOAD bypasses the arithmetic and reports product 0 directly.
//  Revision    : 1.0  initial release
// ============================================================================
module robertson_mul_seq #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  robertson_mul_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  // Counter value seen in the last SHIFT of the add/shift loop; the loop
  // runs WIDTH-1 times, the multiplier MSB is handled by CORRECT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

  if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
    $error("robertson_mul_seq: WIDTH must be in 4..32");
  end

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LOAD        = 4'd1,
    ADD         = 4'd2,
    SHIFT       = 4'd3,
    CORRECT     = 4'd4,
    FINAL_SHIFT = 4'd5,
    OUT_A       = 4'd6,
    OUT_Q       = 4'd7,
    DONE        = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;        // accumulator (high half)
  logic [WIDTH-1:0]     q_q, q_d;        // multiplier / low half
  logic [WIDTH-1:0]     m_q, m_d;        // multiplicand
  logic                 f_q, f_d;        // sign of the partial product
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // {F,A,Q} shifted right by one: F enters A[MSB], A[0] enters Q[MSB].
  logic [2*WIDTH-1:0]   shifted;
  // A - M evaluated one bit wider. After a SHIFT, A[MSB] equals F, so the
  // sign extension of A is exact and the extra bit is the true sign of the
  // corrected partial product (needed e.g. for -2^(W-1) * -2^(W-1)).
  logic [WIDTH:0]       corr_diff;

  assign shifted   = {f_q, a_q, q_q[WIDTH-1:1]};
  assign corr_diff = {a_q[WIDTH-1], a_q} - {m_q[WIDTH-1], m_q};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      f_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      f_q       <= f_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    f_d       = f_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        m_d     = bus.m_i;
        q_d     = bus.q_i;
        a_d     = '0;
        f_d     = 1'b0;
        cnt_d   = '0;
        state_d = ADD;
`ifdef ROBERTSON_ZERO_SKIP_EN
        // Any zero operand gives a zero product; skip the iterations.
        if ((bus.m_i == '0) || (bus.q_i == '0)) begin
          product_d = '0;
          state_d   = OUT_A;
        end
`endif
      end

      ADD: begin
        if (q_q[0]) begin
          a_d = a_q + m_q;
        end
        // Once a negative multiplicand has been added the partial product
        // stays negative, so F is sticky.
        f_d     = f_q | (m_q[WIDTH-1] & q_q[0]);
        state_d = SHIFT;
      end

      SHIFT: begin
        {a_d, q_d} = shifted;
        cnt_d      = cnt_q + CNT_W'(1);
        state_d    = (cnt_q < CNT_LAST) ? ADD : CORRECT;
      end

      CORRECT: begin
        // Multiplier MSB carries weight -2^(WIDTH-1): subtract instead of add.
        if (q_q[0]) begin
          a_d = corr_diff[WIDTH-1:0];
          f_d = corr_diff[WIDTH];
        end
        state_d = FINAL_SHIFT;
      end

      FINAL_SHIFT: begin
        {a_d, q_d} = shifted;
        product_d  = shifted;
        state_d    = OUT_A;
      end

      OUT_A: begin
        state_d = OUT_Q;
      end

      OUT_Q: begin
        state_d = DONE;
      end

      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // --------------------------------------------------------------------------
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.res_valid = (state_q == OUT_A) || (state_q == OUT_Q);
  assign bus.res_hi    = (state_q == OUT_A);
  assign bus.product   = product_q;
  assign bus.res_o     = (state_q == OUT_A) ? product_q[2*WIDTH-1:WIDTH] :
                         (state_q == OUT_Q) ? product_q[WIDTH-1:0]       :
                                              '0;

endmodule
`default_nettype wire

// File: tb/tb_robertson_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_robertson_mul_seq
//  Description : Self-checking bench for robertson_mul_seq (WIDTH=8).
//                Directed vectors with hand-computed products, latency,
//                result beats, start-ignore, reset abort and a back-to-back
//                run against a signed reference product.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_robertson_mul_seq;

  localparam int W        = 8;
  localparam int FULL_LAT = 20;
`ifdef ROBERTSON_ZERO_SKIP_EN
  localparam int ZERO_LAT = 4;
`else
  localparam int ZERO_LAT = 20;
`endif
  localparam int MAX_CYC  = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  robertson_mul_seq_if #(.WIDTH(W)) bus ();

  robertson_mul_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observations of the last operation
  int          r_done_cyc;
  int          r_nvalid;
  int          r_ndone;
  logic [7:0]  r_b0, r_b1;
  logic        r_h0, r_h1;
  logic [15:0] r_prod;
  bit          r_busy_ok;
  bit          r_zero_ok;
  bit          r_idle_ok;

  // Starts one operation and observes it up to the first IDLE cycle after
  // done. Cycle 1 is the cycle right after the edge that samples start.
  // If inj_cyc > 0, start is re-asserted with other operands in that cycle.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                        input int inj_cyc, input logic [7:0] inj_m,
                        input logic [7:0] inj_q);
    int  cyc;
    bit  seen;
    r_done_cyc = 0; r_nvalid = 0; r_ndone = 0;
    r_b0 = '0; r_b1 = '0; r_h0 = 1'b0; r_h1 = 1'b0; r_prod = '0;
    r_busy_ok = 1'b1; r_zero_ok = 1'b1; r_idle_ok = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.m_i = m; bus.q_i = q;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!seen && cyc <= MAX_CYC) begin
      if (!bus.busy) r_busy_ok = 1'b0;
      if (bus.res_valid) begin
        if (r_nvalid == 0) begin r_b0 = bus.res_o; r_h0 = bus.res_hi; end
        else if (r_nvalid == 1) begin r_b1 = bus.res_o; r_h1 = bus.res_hi; end
        r_nvalid++;
      end else if (bus.res_o !== 8'h00) begin
        r_zero_ok = 1'b0;
      end
      if (bus.done) begin
        r_ndone++;
        r_done_cyc = cyc;
        r_prod = bus.product;
        seen = 1'b1;
      end
      if (cyc == inj_cyc) begin
        bus.start = 1'b1; bus.m_i = inj_m; bus.q_i = inj_q;
      end
      @(posedge clk); #1;
      if (cyc == inj_cyc) bus.start = 1'b0;
      cyc++;
    end
    // Now in the cycle after DONE: must be idle with nothing pending.
    if (bus.busy) r_idle_ok = 1'b0;
    if (bus.done) r_ndone++;
    if (bus.res_valid) r_nvalid++;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.m_i = '0; bus.q_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if ({bus.res_valid, bus.res_hi} !== 2'b00) begin errors++; $display("FAIL reset_valid_hi: got %b expected 00", {bus.res_valid, bus.res_hi}); end
    checks++; if (bus.res_o !== 8'h00) begin errors++; $display("FAIL reset_res_o: got %h expected 00", bus.res_o); end
    checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", bus.product); end
    // rst and start at the same edge: reset must win
    @(negedge clk);
    bus.start = 1'b1; bus.m_i = 8'd5; bus.q_i = 8'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_priority_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic;
    run_op(8'd5, 8'd3, 0, 8'h00, 8'h00);
    checks++; if (r_done_cyc != FULL_LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", r_done_cyc, FULL_LAT); end
    checks++; if (r_prod !== 16'h000F) begin errors++; $display("FAIL basic_product: got %h expected 000f", r_prod); end
    checks++; if (r_nvalid != 2) begin errors++; $display("FAIL basic_beats: got %0d expected 2", r_nvalid); end
    checks++; if ({r_h0, r_b0} !== {1'b1, 8'h00}) begin errors++; $display("FAIL basic_beat_hi: got hi=%b %h expected hi=1 00", r_h0, r_b0); end
    checks++; if ({r_h1, r_b1} !== {1'b0, 8'h0F}) begin errors++; $display("FAIL basic_beat_lo: got hi=%b %h expected hi=0 0f", r_h1, r_b1); end
    checks++; if (r_ndone != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", r_ndone); end
    checks++; if (!r_busy_ok || !r_idle_ok) begin errors++; $display("FAIL basic_busy: got busy_ok=%b idle_ok=%b expected 1 1", r_busy_ok, r_idle_ok); end
    checks++; if (!r_zero_ok) begin errors++; $display("FAIL basic_res_o_idle_zero: got nonzero res_o expected 00"); end
  endtask

  task automatic test_corners;
    // {m, q, product}
    logic [31:0] vec [0:9] = '{
      {8'h80, 8'h80, 16'h4000},   // -128 * -128 =  16384
      {8'hFF, 8'h7F, 16'hFF81},   //   -1 *  127 =   -127
      {8'h7F, 8'h80, 16'hC080},   //  127 * -128 = -16256
      {8'h80, 8'h7F, 16'hC080},   // -128 *  127 = -16256
      {8'hF9, 8'hF7, 16'h003F},   //   -7 *   -9 =     63
      {8'h0C, 8'hF5, 16'hFF7C},   //   12 *  -11 =   -132
      {8'hFF, 8'hFF, 16'h0001},   //   -1 *   -1 =      1
      {8'h7F, 8'h7F, 16'h3F01},   //  127 *  127 =  16129
      {8'h80, 8'h01, 16'hFF80},   // -128 *    1 =   -128
      {8'h01, 8'h80, 16'hFF80}    //    1 * -128 =   -128
    };
    logic [31:0] v;
    for (int i = 0; i < 10; i++) begin
      v = vec[i];
      run_op(v[31:24], v[23:16], 0, 8'h00, 8'h00);
      checks++; if (r_prod !== v[15:0]) begin errors++; $display("FAIL corner_product[%0d]: got %h expected %h", i, r_prod, v[15:0]); end
      checks++; if ({r_b0, r_b1} !== v[15:0]) begin errors++; $display("FAIL corner_beats[%0d]: got %h %h expected %h", i, r_b0, r_b1, v[15:0]); end
      checks++; if (r_done_cyc != FULL_LAT) begin errors++; $display("FAIL corner_latency[%0d]: got %0d expected %0d", i, r_done_cyc, FULL_LAT); end
    end
  endtask

  task automatic test_zero;
    // Previous product is nonzero, so a stale register would show here.
    run_op(8'h00, 8'hF9, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'h0000) begin errors++; $display("FAIL zero_m_product: got %h expected 0000", r_prod); end
    checks++; if (r_done_cyc != ZERO_LAT) begin errors++; $display("FAIL zero_m_latency: got %0d expected %0d", r_done_cyc, ZERO_LAT); end
    checks++; if ({r_nvalid, r_h0, r_h1} !== {32'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL zero_m_beats: got n=%0d hi=%b%b expected n=2 hi=10", r_nvalid, r_h0, r_h1); end
    run_op(8'h5A, 8'h03, 0, 8'h00, 8'h00);  // 90*3 = 270
    checks++; if (r_prod !== 16'h010E) begin errors++; $display("FAIL zero_pre_product: got %h expected 010e", r_prod); end
    run_op(8'h09, 8'h00, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'h0000) begin errors++; $display("FAIL zero_q_product: got %h expected 0000", r_prod); end
    checks++; if (r_done_cyc != ZERO_LAT) begin errors++; $display("FAIL zero_q_latency: got %0d expected %0d", r_done_cyc, ZERO_LAT); end
  endtask

  task automatic test_ignore_start;
    run_op(8'd5, 8'd3, 5, 8'h9C, 8'h4D);
    checks++; if (r_prod !== 16'h000F) begin errors++; $display("FAIL ignore_product: got %h expected 000f", r_prod); end
    checks++; if (r_done_cyc != FULL_LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", r_done_cyc, FULL_LAT); end
    checks++; if (!r_busy_ok) begin errors++; $display("FAIL ignore_busy: got busy low expected high"); end
    checks++; if (!r_idle_ok || r_ndone != 1) begin errors++; $display("FAIL ignore_idle_after: got idle_ok=%b done=%0d expected 1 1", r_idle_ok, r_ndone); end
    // Operands now differ from the latched ones; a late latch would show.
    checks++; if ({r_b0, r_b1} !== 16'h000F) begin errors++; $display("FAIL ignore_beats: got %h %h expected 00 0f", r_b0, r_b1); end
  endtask

  task automatic test_reset_abort;
    int bad_done;
    int bad_valid;
    bad_done = 0; bad_valid = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.m_i = 8'hCE; bus.q_i = 8'h03;  // -50 * 3
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end   // now sampled in cycle 9
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({bus.busy, bus.done, bus.res_valid, bus.res_hi} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b expected 0000", {bus.busy, bus.done, bus.res_valid, bus.res_hi}); end
    checks++; if ({bus.res_o, bus.product} !== 24'h000000) begin errors++; $display("FAIL abort_data: got %h %h expected 00 0000", bus.res_o, bus.product); end
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) bad_done++;
      if (bus.res_valid) bad_valid++;
    end
    checks++; if (bad_done != 0 || bad_valid != 0) begin errors++; $display("FAIL abort_stale: got done=%0d valid=%0d expected 0 0", bad_done, bad_valid); end
    run_op(8'hCE, 8'h03, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'hFF6A) begin errors++; $display("FAIL abort_restart_product: got %h expected ff6a", r_prod); end
    checks++; if (r_done_cyc != FULL_LAT || r_ndone != 1) begin errors++; $display("FAIL abort_restart_done: got cyc=%0d n=%0d expected %0d 1", r_done_cyc, r_ndone, FULL_LAT); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  m, q;
    logic [15:0] exp_p;
    int          sm, sq, prod_i, exp_lat;
    for (int i = 0; i < 200; i++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      if (i % 50 == 7)  m = 8'h00;
      if (i % 50 == 31) q = 8'h00;
      sm = $signed(m);
      sq = $signed(q);
      prod_i = sm * sq;
      exp_p = prod_i[15:0];
      exp_lat = (m == 8'h00 || q == 8'h00) ? ZERO_LAT : FULL_LAT;
      run_op(m, q, 0, 8'h00, 8'h00);
      checks++; if (r_prod !== exp_p) begin errors++; $display("FAIL b2b_product[%0d]: m=%h q=%h got %h expected %h", i, m, q, r_prod, exp_p); end
      checks++; if (r_ndone != 1 || r_nvalid != 2) begin errors++; $display("FAIL b2b_counts[%0d]: got done=%0d valid=%0d expected 1 2", i, r_ndone, r_nvalid); end
      checks++; if (r_done_cyc != exp_lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, r_done_cyc, exp_lat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
